// File: rtl/ping_ram_dot_pkg.sv
// Shared definitions for the ping_ram dot-product engine.
// Contents: FSM state encoding, command format codes, finish_signal status bit positions
// and the bus word size.
package ping_ram_dot_pkg;

  // State encoding is kept as plain constants so legacy tools can consume it unchanged.
  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StRdIn = 3'd1;
  localparam state_t StWtIn = 3'd2;
  localparam state_t StRdW  = 3'd3;
  localparam state_t StWtW  = 3'd4;
  localparam state_t StMac  = 3'd5;
  localparam state_t StWr   = 3'd6;
  localparam state_t StDone = 3'd7;

  localparam logic [1:0] FMT_I8X4  = 2'd0;
  localparam logic [1:0] FMT_I16X2 = 2'd1;

  localparam int unsigned DONE_B = 31;
  localparam int unsigned BUSY_B = 30;
  localparam int unsigned ERR_B  = 29;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/ping_ram_dot_engine_if.sv
// Avalon-MM bus bundle between the dot engine (master) and the ping_ram slave.
// Signals: byte address, read/write strobes, write data, byte enables, burst count,
// read data with its valid strobe, and the slave stall (waitrequest).
interface ping_ram_dot_engine_if;
  logic [26:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_burstcount;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/ping_ram_dot_engine_lane_sum.sv
// Combinational packed-lane multiply and sum.
// Ports:
//   fmt_i  - lane format (FMT_I8X4: four int8 lanes, FMT_I16X2: two int16 lanes)
//   a_i    - packed input word
//   b_i    - packed weight word
//   sum_o  - signed sum of lane products, sign-extended to 34 bits
module dot_lane_sum
  import ping_ram_dot_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [33:0] sum_o
);

  logic signed [15:0] p8  [4];
  logic signed [31:0] p16 [2];
  logic        [17:0] s8;
  logic        [32:0] s16;

  always_comb begin
    s8 = '0;
    for (int i = 0; i < 4; i++) begin
      p8[i] = $signed({{8{a_i[8*i+7]}}, a_i[8*i +: 8]}) *
              $signed({{8{b_i[8*i+7]}}, b_i[8*i +: 8]});
      s8 = s8 + {{2{p8[i][15]}}, p8[i]};
    end
    s16 = '0;
    for (int j = 0; j < 2; j++) begin
      p16[j] = $signed({{16{a_i[16*j+15]}}, a_i[16*j +: 16]}) *
               $signed({{16{b_i[16*j+15]}}, b_i[16*j +: 16]});
      s16 = s16 + {p16[j][31], p16[j]};
    end
    case (fmt_i)
      FMT_I8X4:  sum_o = {{16{s8[17]}}, s8};
      FMT_I16X2: sum_o = {s16[32], s16};
      default:   sum_o = '0;
    endcase
  end

endmodule

// File: rtl/ping_ram_dot_engine.sv
// Dot-product engine mastering the ping_ram Avalon-MM slave.
// A rising edge on data_type[31] starts a job: LEN words from input_addr and weight_addr
// are multiplied lane-wise (fmt 0: 4x int8, fmt 1: 2x int16) and accumulated; the 32-bit
// result is written to output_addr. Misaligned addresses or an unknown fmt flag an error
// without touching the bus.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   input_addr        - input vector byte address ([26:0] used)
//   weight_addr       - weight vector byte address ([26:0] used)
//   output_addr       - result byte address ([26:0] used)
//   data_type         - command: [31] go, [25:24] fmt, [LEN_W-1:0] length in words
//   finish_signal     - status: [31] done, [30] busy, [29] err, [LEN_W-1:0] words processed
//   avm               - Avalon-MM master bundle
// Build option: define PING_RAM_DOT_ACC_SAT_EN to saturate the result to signed 32 bits
// instead of wrapping.
module ping_ram_dot_engine
  import ping_ram_dot_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  input_addr,
  input  logic [31:0]                  weight_addr,
  input  logic [31:0]                  output_addr,
  input  logic [31:0]                  data_type,
  output logic [31:0]                  finish_signal,
  ping_ram_dot_engine_if.master        avm
);

  state_t             state_q, state_d;
  logic               go_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         fmt_q, fmt_d;
  logic [26:0]        in_base_q, in_base_d;
  logic [26:0]        w_base_q, w_base_d;
  logic [26:0]        out_addr_q, out_addr_d;
  logic [26:0]        off_q, off_d;
  logic [31:0]        in_word_q, in_word_d;
  logic [31:0]        w_word_q, w_word_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               go_rise;
  logic [1:0]         start_fmt;
  logic [LEN_W-1:0]   start_len;
  logic               start_bad;
  logic [33:0]        lane_sum;
  logic [ACC_W-1:0]   lane_ext;
  logic [31:0]        result;

  assign go_rise   = data_type[31] & ~go_q;
  assign start_fmt = data_type[25:24];
  assign start_len = data_type[LEN_W-1:0];
  assign start_bad = ((start_fmt != FMT_I8X4) && (start_fmt != FMT_I16X2)) ||
                     (|input_addr[1:0]) || (|weight_addr[1:0]) || (|output_addr[1:0]);

  dot_lane_sum u_lane_sum (
    .fmt_i (fmt_q),
    .a_i   (in_word_q),
    .b_i   (w_word_q),
    .sum_o (lane_sum)
  );

  assign lane_ext = ACC_W'($signed(lane_sum));

`ifdef PING_RAM_DOT_ACC_SAT_EN
  logic [ACC_W-32:0] acc_hi;
  logic              unused_bits;
  assign acc_hi = acc_q[ACC_W-1:31];
  // In range exactly when every bit above bit 30 matches the sign.
  always_comb begin
    if ((&acc_hi) || !(|acc_hi)) begin
      result = acc_q[31:0];
    end else if (acc_q[ACC_W-1]) begin
      result = 32'h8000_0000;
    end else begin
      result = 32'h7FFF_FFFF;
    end
  end
  assign unused_bits = ^{input_addr[31:27], weight_addr[31:27], output_addr[31:27], data_type};
`else
  logic unused_bits;
  assign result      = acc_q[31:0];
  assign unused_bits = ^{input_addr[31:27], weight_addr[31:27], output_addr[31:27], data_type,
                         acc_q};
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    fmt_d      = fmt_q;
    in_base_d  = in_base_q;
    w_base_d   = w_base_q;
    out_addr_d = out_addr_q;
    off_d      = off_q;
    in_word_d  = in_word_q;
    w_word_d   = w_word_q;
    acc_d      = acc_q;
    count_d    = count_q;
    done_d     = done_q;
    busy_d     = busy_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (go_rise) begin
          len_d      = start_len;
          fmt_d      = start_fmt;
          in_base_d  = input_addr[26:0];
          w_base_d   = weight_addr[26:0];
          out_addr_d = output_addr[26:0];
          count_d    = '0;
          if (start_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            acc_d   = '0;
            off_d   = '0;
            state_d = (start_len == '0) ? StWr : StRdIn;
          end
        end
      end
      StRdIn: if (!avm.avm_waitrequest) state_d = StWtIn;
      StWtIn: begin
        if (avm.avm_readdatavalid) begin
          in_word_d = avm.avm_readdata;
          state_d   = StRdW;
        end
      end
      StRdW: if (!avm.avm_waitrequest) state_d = StWtW;
      StWtW: begin
        if (avm.avm_readdatavalid) begin
          w_word_d = avm.avm_readdata;
          state_d  = StMac;
        end
      end
      StMac: begin
        acc_d   = acc_q + lane_ext;
        count_d = count_q + LEN_W'(1);
        off_d   = off_q + 27'(WORD_BYTES);
        state_d = (count_d < len_q) ? StRdIn : StWr;
      end
      StWr: if (!avm.avm_waitrequest) state_d = StDone;
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      go_q       <= 1'b0;
      len_q      <= '0;
      fmt_q      <= '0;
      in_base_q  <= '0;
      w_base_q   <= '0;
      out_addr_q <= '0;
      off_q      <= '0;
      in_word_q  <= '0;
      w_word_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= data_type[31];
      len_q      <= len_d;
      fmt_q      <= fmt_d;
      in_base_q  <= in_base_d;
      w_base_q   <= w_base_d;
      out_addr_q <= out_addr_d;
      off_q      <= off_d;
      in_word_q  <= in_word_d;
      w_word_q   <= w_word_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Requests are decoded from state, so they hold steady through waitrequest and drop
  // the cycle after acceptance.
  always_comb begin
    avm.avm_read      = 1'b0;
    avm.avm_write     = 1'b0;
    avm.avm_address   = '0;
    avm.avm_writedata = '0;
    unique case (state_q)
      StRdIn: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = in_base_q + off_q;
      end
      StRdW: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = w_base_q + off_q;
      end
      StWr: begin
        avm.avm_write     = 1'b1;
        avm.avm_address   = out_addr_q;
        avm.avm_writedata = result;
      end
      default: ;
    endcase
  end

  assign avm.avm_byteenable = 4'hF;
  assign avm.avm_burstcount = 1'b1;

  always_comb begin
    finish_signal               = '0;
    finish_signal[DONE_B]       = done_q;
    finish_signal[BUSY_B]       = busy_q;
    finish_signal[ERR_B]        = err_q;
    finish_signal[LEN_W-1:0]    = count_q;
  end

endmodule

// File: tb/tb_ping_ram_dot_engine.sv
module tb_ping_ram_dot_engine;
  import ping_ram_dot_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] input_addr, weight_addr, output_addr, data_type;
  logic [31:0] finish_signal;

  ping_ram_dot_engine_if bus ();

  ping_ram_dot_engine #(.ACC_W(40), .LEN_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .input_addr    (input_addr),
    .weight_addr   (weight_addr),
    .output_addr   (output_addr),
    .data_type     (data_type),
    .finish_signal (finish_signal),
    .avm           (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [26:0]];

  // Slave behaviour, set by the tests
  int rd_stall_first = 0;
  int rd_stall_other = 0;
  int wr_stall       = 0;
  int rd_lat         = 1;
  int rd_base        = 0;

  // Slave / monitor bookkeeping, owned by the always block below
  int          reads_acc = 0, writes_acc = 0, req_cyc = 0, stab_err = 0;
  int          rd_stall_cyc = 0, wr_stall_cyc = 0;
  int          rd_req_cyc = 0, wr_req_cyc = 0, rd_pend = 0;
  logic [31:0] rd_pend_data;
  logic [26:0] wr_addr_last;
  logic [31:0] wr_data_last;
  logic        prev_stall = 1'b0, prev_rd, prev_wr;
  logic [26:0] prev_addr;
  logic [31:0] prev_wdata;

  int cur_rd_stall;
  assign cur_rd_stall = (reads_acc == rd_base) ? rd_stall_first : rd_stall_other;
  assign bus.avm_waitrequest = (bus.avm_read && (rd_req_cyc < cur_rd_stall)) ||
                               (bus.avm_write && (wr_req_cyc < wr_stall));

  always @(posedge clk) begin
    bus.avm_readdatavalid <= 1'b0;
    if (bus.avm_read || bus.avm_write) req_cyc <= req_cyc + 1;
    if (prev_stall && !reset && ((bus.avm_read !== prev_rd) || (bus.avm_write !== prev_wr) ||
        (bus.avm_address !== prev_addr) || (bus.avm_writedata !== prev_wdata)))
      stab_err <= stab_err + 1;
    prev_stall <= !reset && (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
    prev_rd    <= bus.avm_read;
    prev_wr    <= bus.avm_write;
    prev_addr  <= bus.avm_address;
    prev_wdata <= bus.avm_writedata;
    if (bus.avm_read && bus.avm_waitrequest) begin
      rd_req_cyc   <= rd_req_cyc + 1;
      rd_stall_cyc <= rd_stall_cyc + 1;
    end else begin
      rd_req_cyc <= 0;
    end
    if (bus.avm_write && bus.avm_waitrequest) begin
      wr_req_cyc   <= wr_req_cyc + 1;
      wr_stall_cyc <= wr_stall_cyc + 1;
    end else begin
      wr_req_cyc <= 0;
    end
    if (rd_pend > 0) begin
      rd_pend <= rd_pend - 1;
      if (rd_pend == 1) begin
        bus.avm_readdatavalid <= 1'b1;
        bus.avm_readdata      <= rd_pend_data;
      end
    end
    if (bus.avm_read && !bus.avm_waitrequest) begin
      reads_acc    <= reads_acc + 1;
      rd_pend      <= rd_lat;
      rd_pend_data <= mem.exists(bus.avm_address) ? mem[bus.avm_address] : 32'hDEAD_BEEF;
    end
    if (bus.avm_write && !bus.avm_waitrequest) begin
      writes_acc   <= writes_acc + 1;
      wr_addr_last <= bus.avm_address;
      wr_data_last <= bus.avm_writedata;
    end
  end

  // Reference: signed lane products summed in wide integer arithmetic.
  function automatic logic [31:0] model_dot(input logic [1:0] fmt, input int len,
                                            input logic [31:0] ia, input logic [31:0] wa);
    longint acc;
    acc = 0;
    for (int i = 0; i < len; i++) begin
      logic [31:0] x, y;
      x = mem[27'(ia + 32'(4 * i))];
      y = mem[27'(wa + 32'(4 * i))];
      if (fmt == 2'd0) begin
        for (int k = 0; k < 4; k++)
          acc += longint'($signed(x[8*k +: 8])) * longint'($signed(y[8*k +: 8]));
      end else begin
        for (int k = 0; k < 2; k++)
          acc += longint'($signed(x[16*k +: 16])) * longint'($signed(y[16*k +: 16]));
      end
    end
`ifdef PING_RAM_DOT_ACC_SAT_EN
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  task automatic start_job(input logic [1:0] fmt, input int len, input logic [31:0] ia,
                           input logic [31:0] wa, input logic [31:0] oa);
    logic [31:0] dt;
    input_addr  = ia;
    weight_addr = wa;
    output_addr = oa;
    data_type   = 32'h0;
    rd_base     = reads_acc;
    @(negedge clk);
    dt         = 32'h0;
    dt[31]     = 1'b1;
    dt[25:24]  = fmt;
    dt[15:0]   = len[15:0];
    data_type  = dt;
    @(negedge clk);
    data_type[31] = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (finish_signal[31]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: got done=0 want done=1 within 1000 cycles", name);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic load_s1();
    mem[27'h1000] = 32'h0102_0304;
    mem[27'h1004] = 32'hFF01_0101;
    mem[27'h2000] = 32'h0101_0101;
    mem[27'h2004] = 32'h0202_0202;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    data_type   = 32'h0;
    input_addr  = 32'h0;
    weight_addr = 32'h0;
    output_addr = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if (finish_signal !== 32'h0) begin
      bad++; $display("FAIL rst_status: got %h want 00000000", finish_signal);
    end
    total++;
    if (bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
      bad++; $display("FAIL rst_req: got rd=%b wr=%b want 0 0", bus.avm_read, bus.avm_write);
    end
    total++;
    if (bus.avm_address !== 27'h0 || bus.avm_writedata !== 32'h0) begin
      bad++;
      $display("FAIL rst_bus: got addr=%h wd=%h want 0 0", bus.avm_address, bus.avm_writedata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (finish_signal !== 32'h0 || req_cyc !== 0) begin
      bad++; $display("FAIL idle_after_rst: got status=%h req=%0d want 0 0", finish_signal, req_cyc);
    end
  endtask

  task automatic test_i8x4_basic(input string name);
    int r0, w0;
    load_s1();
    r0 = reads_acc; w0 = writes_acc;
    start_job(2'd0, 2, 32'h1000, 32'h2000, 32'h100);
    wait_done(name);
    total++;
    if (writes_acc - w0 !== 1) begin
      bad++; $display("FAIL %s_nwrites: got %0d want 1", name, writes_acc - w0);
    end
    total++;
    if (wr_addr_last !== 27'h100 || wr_data_last !== 32'h0000_000E) begin
      bad++;
      $display("FAIL %s_write: got %h@%h want 0000000e@100", name, wr_data_last, wr_addr_last);
    end
    total++;
    if (reads_acc - r0 !== 4) begin
      bad++; $display("FAIL %s_nreads: got %0d want 4", name, reads_acc - r0);
    end
    total++;
    if (finish_signal !== 32'h8000_0002) begin
      bad++; $display("FAIL %s_status: got %h want 80000002", name, finish_signal);
    end
  endtask

  task automatic test_i16x2_overflow();
    logic [31:0] want;
`ifdef PING_RAM_DOT_ACC_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'hFFFC_0004;
`endif
    mem[27'h3000] = 32'h7FFF_7FFF; mem[27'h3004] = 32'h7FFF_7FFF;
    mem[27'h4000] = 32'h7FFF_7FFF; mem[27'h4004] = 32'h7FFF_7FFF;
    start_job(2'd1, 2, 32'h3000, 32'h4000, 32'h500);
    wait_done("i16");
    total++;
    if (wr_data_last !== want || wr_addr_last !== 27'h500) begin
      bad++; $display("FAIL i16_result: got %h@%h want %h@500", wr_data_last, wr_addr_last, want);
    end
    total++;
    if (finish_signal !== 32'h8000_0002) begin
      bad++; $display("FAIL i16_status: got %h want 80000002", finish_signal);
    end
  endtask

  task automatic test_waitstates();
    int s0, rs0, ws0;
    s0 = stab_err; rs0 = rd_stall_cyc; ws0 = wr_stall_cyc;
    rd_stall_first = 3; rd_stall_other = 0; wr_stall = 2; rd_lat = 2;
    test_i8x4_basic("wait");
    total++;
    if (stab_err - s0 !== 0) begin
      bad++; $display("FAIL wait_stable: got %0d changes while stalled want 0", stab_err - s0);
    end
    total++;
    if (rd_stall_cyc - rs0 !== 3 || wr_stall_cyc - ws0 !== 2) begin
      bad++;
      $display("FAIL wait_cycles: got rd=%0d wr=%0d want 3 2", rd_stall_cyc - rs0,
               wr_stall_cyc - ws0);
    end
    rd_stall_first = 0; wr_stall = 0; rd_lat = 1;
  endtask

  task automatic test_misaligned();
    int q0;
    q0 = req_cyc;
    start_job(2'd0, 2, 32'h0000_0002, 32'h2000, 32'h100);
    total++;
    if (finish_signal !== 32'hA000_0000) begin
      bad++; $display("FAIL misalign_status: got %h want a0000000", finish_signal);
    end
    repeat (10) @(negedge clk);
    total++;
    if (req_cyc - q0 !== 0) begin
      bad++; $display("FAIL misalign_bus: got %0d request cycles want 0", req_cyc - q0);
    end
    start_job(2'd2, 1, 32'h1000, 32'h2000, 32'h100);
    total++;
    if (finish_signal !== 32'hA000_0000 || req_cyc - q0 !== 0) begin
      bad++; $display("FAIL badfmt: got %h req=%0d want a0000000 0", finish_signal, req_cyc - q0);
    end
  endtask

  task automatic test_zero_len_and_busy();
    int r0, w0;
    r0 = reads_acc; w0 = writes_acc;
    start_job(2'd0, 0, 32'h1000, 32'h2000, 32'h600);
    wait_done("zero");
    total++;
    if (reads_acc - r0 !== 0 || writes_acc - w0 !== 1) begin
      bad++;
      $display("FAIL zero_bus: got rd=%0d wr=%0d want 0 1", reads_acc - r0, writes_acc - w0);
    end
    total++;
    if (wr_data_last !== 32'h0 || wr_addr_last !== 27'h600) begin
      bad++; $display("FAIL zero_write: got %h@%h want 00000000@600", wr_data_last, wr_addr_last);
    end
    total++;
    if (finish_signal !== 32'h8000_0000) begin
      bad++; $display("FAIL zero_status: got %h want 80000000", finish_signal);
    end
    for (int i = 0; i < 3; i++) begin
      mem[27'(32'h5000 + 4 * i)] = $urandom;
      mem[27'(32'h5800 + 4 * i)] = $urandom;
    end
    rd_lat = 3;
    w0 = writes_acc;
    start_job(2'd0, 3, 32'h5000, 32'h5800, 32'h700);
    repeat (4) @(negedge clk);
    data_type[31] = 1'b1;
    repeat (2) @(negedge clk);
    data_type[31] = 1'b0;
    wait_done("busy");
    rd_lat = 1;
    total++;
    if (finish_signal !== 32'h8000_0003) begin
      bad++; $display("FAIL busy_status: got %h want 80000003", finish_signal);
    end
    total++;
    if (writes_acc - w0 !== 1 || wr_data_last !== model_dot(2'd0, 3, 32'h5000, 32'h5800)) begin
      bad++;
      $display("FAIL busy_result: got %h (%0d writes) want %h (1 write)", wr_data_last,
               writes_acc - w0, model_dot(2'd0, 3, 32'h5000, 32'h5800));
    end
  endtask

  task automatic test_reset_mid();
    int  r0;
    bit  hit;
    load_s1();
    rd_lat = 6;
    r0  = reads_acc;
    hit = 1'b0;
    start_job(2'd0, 2, 32'h1000, 32'h2000, 32'h100);
    for (int c = 0; c < 300; c++) begin
      if (reads_acc - r0 == 4) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL rstmid_reach: got %0d reads want 4", reads_acc - r0);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (finish_signal !== 32'h0 || bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0 ||
        bus.avm_address !== 27'h0 || bus.avm_writedata !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_outputs: got st=%h rd=%b wr=%b a=%h wd=%h want all 0", finish_signal,
               bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    rd_lat = 1;
    test_i8x4_basic("after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      logic [1:0]  fmt;
      int          len, w0;
      logic [31:0] ia, wa, oa, want;
      fmt = 2'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      ia  = (n == 0) ? 32'h07FF_FFF8 : ($urandom & 32'h07FF_FFFC);
      wa  = $urandom & 32'h07FF_FFFC;
      oa  = $urandom & 32'h07FF_FFFC;
      for (int i = 0; i < len; i++) mem[27'(ia + 32'(4 * i))] = $urandom;
      for (int i = 0; i < len; i++) mem[27'(wa + 32'(4 * i))] = $urandom;
      want = model_dot(fmt, len, ia, wa);
      rd_stall_first = $urandom_range(0, 2);
      rd_stall_other = $urandom_range(0, 2);
      wr_stall       = $urandom_range(0, 2);
      rd_lat         = $urandom_range(1, 3);
      w0 = writes_acc;
      start_job(fmt, len, ia, wa, oa);
      wait_done("rand");
      total++;
      if (writes_acc - w0 !== 1 || wr_data_last !== want || wr_addr_last !== oa[26:0]) begin
        bad++;
        $display("FAIL rand%0d_result: got %h@%h (%0d writes) want %h@%h (1 write)", n,
                 wr_data_last, wr_addr_last, writes_acc - w0, want, oa[26:0]);
      end
      total++;
      if (finish_signal !== (32'h8000_0000 | 32'(len))) begin
        bad++;
        $display("FAIL rand%0d_status: got %h want %h", n, finish_signal,
                 32'h8000_0000 | 32'(len));
      end
    end
    rd_stall_first = 0; rd_stall_other = 0; wr_stall = 0; rd_lat = 1;
  endtask

  initial begin
    test_reset();
    test_i8x4_basic("i8");
    test_i16x2_overflow();
    test_waitstates();
    test_misaligned();
    test_zero_len_and_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
